// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK cell operation encodings shared by the counter
//
// Purpose : names the four JK cell operations and maps each one to its
//           {j,k} input pair.
// Contents: jk_op_e (HOLD, RESET, SET, TOGGLE), JK_* {j,k} constants,
//           jk_bits() operation-to-{j,k} mapping.

package jk_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      RESET  = 2'b01,
      SET    = 2'b10,
      TOGGLE = 2'b11
   } jk_op_e;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Returns {j,k} for a cell operation.
   function automatic logic [1:0] jk_bits(input jk_op_e op);
      logic [1:0] jk;
      case (op)
         HOLD:    jk = JK_HOLD;
         RESET:   jk = JK_RESET;
         SET:     jk = JK_SET;
         TOGGLE:  jk = JK_TOGGLE;
         default: jk = JK_HOLD;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single-bit JK storage cell with async active-low clear
//
// Purpose: one count bit. On each rising clk edge applies the JK truth
//          table; clear low forces q=0 immediately, independent of clk.
// Ports  : clk   in  rising-edge clock
//          clear in  asynchronous active-low reset
//          j, k  in  JK control (00 hold, 01 reset, 10 set, 11 toggle)
//          q     out stored bit
//          qbar  out complement of q

module jk_cell (
   input  logic clk,
   input  logic clear,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic state_q;
   logic state_d;

   always_comb begin
      state_d = state_q;
      case ({j, k})
         2'b00: state_d = state_q;
         2'b01: state_d = 1'b0;
         2'b10: state_d = 1'b1;
         2'b11: state_d = ~state_q;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= 1'b0;
      end else begin
         state_q <= state_d;
      end
   end

   assign q    = state_q;
   assign qbar = ~state_q;

endmodule

// File: rtl/jk_sync_counter.sv
// rtl/jk_sync_counter.sv - modulo-N up/down counter built from JK cells
//
// Purpose : synchronous modulo-MODULUS up/down counter. Each bit is a
//           jk_cell; this module picks a JK operation per bit every cycle
//           (load > count > hold) and registers the one-cycle wrap pulse.
// Params  : WIDTH (>=2), MODULUS (2..2^WIDTH), count range 0..MODULUS-1
// Ports   : clk      in  rising-edge clock
//           clear    in  asynchronous active-low reset
//           en       in  count enable
//           up       in  1 = increment, 0 = decrement
//           load     in  synchronous parallel load (clamped to MODULUS-1)
//           load_val in  value captured on load
//           q        out current count
//           qbar     out complement of q
//           tc       out terminal count for the current direction
//           wrap     out one-cycle pulse after a wrap step
// Macro   : JK_SYNC_COUNTER_SAT_EN - saturate at the terminal count instead
//           of wrapping; wrap is then tied to 0.

module jk_sync_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             wrap
);

   import jk_pkg::*;

   // One extra bit so MODULUS == 2^WIDTH is representable for the clamp.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic [WIDTH-1:0] load_clamped;
   logic             tc_c;
   logic             lower_ones;
   logic             lower_zeros;
   jk_op_e           op;

   always_comb begin
      tc_c = up ? (q == MAX_VAL) : (q == '0);
   end

   assign tc = tc_c;

   always_comb begin
      load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
      j_vec        = '0;
      k_vec        = '0;
      lower_ones   = 1'b1;
      lower_zeros  = 1'b1;
      op           = HOLD;
      for (int i = 0; i < WIDTH; i++) begin
         op = HOLD;
         if (load) begin
            op = load_clamped[i] ? SET : RESET;
         end else if (en) begin
            if (tc_c) begin
`ifdef JK_SYNC_COUNTER_SAT_EN
               op = HOLD;
`else
               // Wrap: up goes to 0, down reloads MODULUS-1 bit by bit.
               if (up) begin
                  op = RESET;
               end else begin
                  op = MAX_VAL[i] ? SET : RESET;
               end
`endif
            end else if (up ? lower_ones : lower_zeros) begin
               // Ripple-free binary step: a bit flips when every lower bit
               // is 1 (increment) or 0 (decrement).
               op = TOGGLE;
            end
         end
         {j_vec[i], k_vec[i]} = jk_bits(op);
         lower_ones  = lower_ones & q[i];
         lower_zeros = lower_zeros & ~q[i];
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .clear (clear),
         .j     (j_vec[g]),
         .k     (k_vec[g]),
         .q     (q[g]),
         .qbar  (qbar[g])
      );
   end

`ifdef JK_SYNC_COUNTER_SAT_EN
   assign wrap = 1'b0;
`else
   logic wrap_q;
   logic wrap_d;

   always_comb begin
      wrap_d = en && !load && tc_c;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap = wrap_q;
`endif

endmodule
